mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 24 ++
 rtl/mem_load_ext.sv | 21 ++
 rtl/mem_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-serial memory controller: FSM states, access width codes, byte-count helper.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_RD   = 2'd1,
        MC_WR   = 2'd2,
        MC_DONE = 2'd3
    } mc_state_t;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    // Width code 2'b11 is handled as a word access.
    function automatic logic [2:0] mem_bytes(input logic [1:0] width);
        case (width)
            MEM_BYTE: return 3'd1;
            MEM_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load-result extension: picks byte/half/word from a little-endian 32-bit raw value and zero- or
// sign-extends it. Purely combinational.
module mem_load_ext
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  width,
    input  logic        uns,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (width)
            MEM_BYTE: ext = {{24{~uns & raw[7]}},  raw[7:0]};
            MEM_HALF: ext = {{16{~uns & raw[15]}}, raw[15:0]};
            default:  ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide sync RAM port between fetch pass-through and MEM-stage 1/2/4-byte accesses.
// Optional perf counters (fetch pass-through cycles, RD+WR cycles) are built when MEMCTRL_PERF_CNT_EN is defined.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [1:0]        mem_width_i,
    input  logic              mem_unsigned_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic              mem_stall_req_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [DATA_W-1:0] ram_dout_o,
`ifdef MEMCTRL_PERF_CNT_EN
    output logic [31:0]       perf_if_cyc_o,
    output logic [31:0]       perf_mem_cyc_o,
`endif
    input  logic [DATA_W-1:0] ram_din_i
);

    mc_state_t         state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        width_q;
    logic              uns_q;
    logic [31:0]       wdata_q;
    logic [2:0]        cnt_q;
    logic [31:0]       raw_q, raw_nxt, ext_dat;
    logic [31:0]       rdata_q;
    logic [2:0]        nbytes;
    logic [1:0]        cap_lane;
    logic [ADDR_W-1:0] byte_addr;

    assign nbytes    = mem_bytes(width_q);
    assign cap_lane  = cnt_q[1:0] - 2'd1;
    assign byte_addr = addr_q + ADDR_W'(cnt_q);

    assign if_data_o   = ram_din_i;
    assign mem_rdata_o = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) state <= MC_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        ram_addr_o      = if_addr_i;
        ram_wr_o        = 1'b0;
        ram_dout_o      = '0;
        mem_stall_req_o = 1'b0;
        mem_done_o      = 1'b0;
        case (state)
            MC_IDLE: begin
                if (mem_req_i) begin
                    mem_stall_req_o = 1'b1;
                    state_nxt       = mem_we_i ? MC_WR : MC_RD;
                end
            end
            MC_RD: begin
                // One extra cycle after the last issue collects the final byte.
                mem_stall_req_o = 1'b1;
                ram_addr_o      = byte_addr;
                if (cnt_q == nbytes) state_nxt = MC_DONE;
            end
            MC_WR: begin
                mem_stall_req_o = 1'b1;
                ram_addr_o      = byte_addr;
                ram_wr_o        = 1'b1;
                ram_dout_o      = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                if (cnt_q == nbytes - 3'd1) state_nxt = MC_DONE;
            end
            MC_DONE: begin
                mem_done_o = 1'b1;
                state_nxt  = MC_IDLE;
            end
            default: state_nxt = MC_IDLE;
        endcase
    end

    // RAM data lags the address by one cycle, so lane k fills while count is k+1.
    always_comb begin
        raw_nxt = raw_q;
        if (state == MC_RD && cnt_q != 3'd0)
            raw_nxt[{cap_lane, 3'b000} +: 8] = ram_din_i;
    end

    mem_load_ext u_load_ext (
        .width (width_q),
        .uns   (uns_q),
        .raw   (raw_nxt),
        .ext   (ext_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            width_q <= MEM_BYTE;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            raw_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                MC_IDLE: begin
                    if (mem_req_i) begin
                        addr_q  <= mem_addr_i;
                        width_q <= mem_width_i;
                        uns_q   <= mem_unsigned_i;
                        wdata_q <= mem_wdata_i;
                        cnt_q   <= '0;
                        raw_q   <= '0;
                    end
                end
                MC_RD: begin
                    raw_q <= raw_nxt;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == nbytes) rdata_q <= ext_dat;
                end
                MC_WR: cnt_q <= cnt_q + 3'd1;
                default: ;
            endcase
        end
    end

`ifdef MEMCTRL_PERF_CNT_EN
    logic passthru;
    assign passthru = (state == MC_IDLE && !mem_req_i) || state == MC_DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_cyc_o  <= '0;
            perf_mem_cyc_o <= '0;
        end else begin
            if (if_req_i && passthru)                 perf_if_cyc_o  <= perf_if_cyc_o + 32'd1;
            if (state == MC_RD || state == MC_WR)     perf_mem_cyc_o <= perf_mem_cyc_o + 32'd1;
        end
    end
`else
    // Fetch ownership is advisory; without the counters nothing consumes it.
    logic unused_if_req;
    assign unused_if_req = if_req_i;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte RAM model, directed loads/stores, and a monitor that checks
// completions and RAM writes against queued expectations.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [7:0]  if_data;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [1:0]  mem_width = 2'b00;
    logic        mem_unsigned = 1'b0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall_req;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'h00;
`ifdef MEMCTRL_PERF_CNT_EN
    logic [31:0] perf_if_cyc, perf_mem_cyc;
`endif

    mem_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .if_req_i        (if_req),
        .if_addr_i       (if_addr),
        .if_data_o       (if_data),
        .mem_req_i       (mem_req),
        .mem_we_i        (mem_we),
        .mem_addr_i      (mem_addr),
        .mem_width_i     (mem_width),
        .mem_unsigned_i  (mem_unsigned),
        .mem_wdata_i     (mem_wdata),
        .mem_rdata_o     (mem_rdata),
        .mem_done_o      (mem_done),
        .mem_stall_req_o (mem_stall_req),
        .ram_addr_o      (ram_addr),
        .ram_wr_o        (ram_wr),
        .ram_dout_o      (ram_dout),
`ifdef MEMCTRL_PERF_CNT_EN
        .perf_if_cyc_o   (perf_if_cyc),
        .perf_mem_cyc_o  (perf_mem_cyc),
`endif
        .ram_din_i       (ram_din)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte RAM model, 4 KiB window on the low address bits; preload port used only during reset.
    logic [7:0]  ram [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = 12'h0;
    logic [7:0]  pre_dat = 8'h0;
    always @(posedge clk) begin
        if (pre_we)      ram[pre_addr] <= pre_dat;
        else if (ram_wr) ram[ram_addr[11:0]] <= ram_dout;
        ram_din <= ram[ram_addr[11:0]];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic [31:0] dat; int cy; } done_t;
    typedef struct { logic [31:0] addr; logic [7:0] dat; int cy; } wr_t;
    done_t done_q[$];
    wr_t   wr_q[$];
    bit    mon_en = 1'b0;
    logic [31:0] last_rdata = 32'h0;

    // Monitor: every completion and every RAM write must match the head of its queue.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (mem_done) begin
                if (done_q.size() == 0) chk(1'b0, "unexpected_done", mem_rdata, 32'h0);
                else begin
                    done_t e;
                    e = done_q.pop_front();
                    chk(mem_rdata === e.dat, "rdata", mem_rdata, e.dat);
                    chk(cyc == e.cy, "done_cycle", 32'(cyc), 32'(e.cy));
                end
            end
            if (ram_wr) begin
                if (wr_q.size() == 0) chk(1'b0, "unexpected_write", ram_addr, 32'h0);
                else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk(ram_addr === w.addr, "wr_addr", ram_addr, w.addr);
                    chk({24'h0, ram_dout} === {24'h0, w.dat}, "wr_data", {24'h0, ram_dout}, {24'h0, w.dat});
                    chk(cyc == w.cy, "wr_cycle", 32'(cyc), 32'(w.cy));
                end
            end
        end
    end

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = a; pre_dat = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Issues one MEM access and waits (bounded) for its completion; lat counts from the accept cycle.
    task automatic do_mem(input logic we, input logic [31:0] a, input logic [1:0] w, input logic u,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input int lat);
        int  acc;
        int  nb;
        int  stall_bad;
        bit  got;
        done_t d;
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = we; mem_addr = a; mem_width = w; mem_unsigned = u; mem_wdata = wd;
        acc = cyc;
        nb = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
        if (we) begin
            for (int k = 0; k < nb; k++) begin
                wr_t x;
                x.addr = a + 32'(k);
                x.dat  = wd[8*k +: 8];
                x.cy   = acc + 1 + k;
                wr_q.push_back(x);
            end
        end else last_rdata = exp_rd;
        d.dat = last_rdata;
        d.cy  = acc + lat;
        done_q.push_back(d);
        got = 1'b0;
        stall_bad = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (mem_done) begin
                got = 1'b1;
                chk(mem_stall_req == 1'b0, "stall_in_done", {31'h0, mem_stall_req}, 32'h0);
                chk(ram_addr === if_addr, "passthru_in_done", ram_addr, if_addr);
            end else if (mem_stall_req !== 1'b1) stall_bad++;
        end
        chk(got, "done_timeout", {31'h0, got}, 32'h1);
        chk(stall_bad == 0, "stall_cycles", 32'(stall_bad), 32'h0);
        @(posedge clk); #1;
        mem_req = 1'b0; mem_we = 1'b0;
    endtask

    logic [7:0] pt_exp [4];

    initial begin
        pt_exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        // Preload while the DUT is held in reset.
        for (int i = 0; i < 4; i++) preload(12'h040 + 12'(i), pt_exp[i]);
        preload(12'h100, 8'h11); preload(12'h101, 8'h22);
        preload(12'h102, 8'h33); preload(12'h103, 8'h44);
        preload(12'h200, 8'h80); preload(12'h202, 8'h34); preload(12'h203, 8'h92);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk(mem_done == 1'b0, "rst_done", {31'h0, mem_done}, 32'h0);
        chk(mem_stall_req == 1'b0, "rst_stall", {31'h0, mem_stall_req}, 32'h0);
        chk(ram_wr == 1'b0, "rst_ram_wr", {31'h0, ram_wr}, 32'h0);
        chk(mem_rdata === 32'h0, "rst_rdata", mem_rdata, 32'h0);
        mon_en = 1'b1;

        // Fetch pass-through: address follows if_addr, data one cycle later.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i < 4) begin if_req = 1'b1; if_addr = 32'h40 + 32'(i); end
            @(negedge clk);
            if (i < 4) begin
                chk(ram_addr === if_addr, "pt_addr", ram_addr, if_addr);
                chk(mem_stall_req == 1'b0, "pt_stall", {31'h0, mem_stall_req}, 32'h0);
            end
            if (i > 0) chk(if_data === pt_exp[i-1], "pt_data", {24'h0, if_data}, {24'h0, pt_exp[i-1]});
        end
        if_req = 1'b0;

        do_mem(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 32'h44332211, 6);   // LW
        do_mem(1'b0, 32'h200, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 3);   // LB
        do_mem(1'b0, 32'h200, 2'b00, 1'b1, 32'h0, 32'h00000080, 3);   // LBU
        do_mem(1'b0, 32'h202, 2'b01, 1'b0, 32'h0, 32'hFFFF9234, 4);   // LH
        do_mem(1'b1, 32'h300, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 5);   // SW
        do_mem(1'b0, 32'h300, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 6);   // LW readback
        do_mem(1'b0, 32'h302, 2'b01, 1'b1, 32'h0, 32'h0000DEAD, 4);   // LHU

        // Fetch and MEM requesting together: MEM served, pass-through back in DONE.
        if_req = 1'b1; if_addr = 32'h41;
        do_mem(1'b0, 32'h200, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 3);
        @(negedge clk);
        chk(if_data === 8'hBB, "pt_after_mem", {24'h0, if_data}, 32'hBB);
        if_req = 1'b0;

        // Reset during the third RD cycle abandons the load.
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; mem_width = 2'b10; mem_unsigned = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; mem_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk(mem_stall_req == 1'b0, "abort_stall", {31'h0, mem_stall_req}, 32'h0);
        chk(mem_rdata === 32'h0, "abort_rdata", mem_rdata, 32'h0);
        chk(ram_addr === if_addr, "abort_passthru", ram_addr, if_addr);
        last_rdata = 32'h0;
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (mem_done || ram_wr) seen++;
            end
            chk(seen == 0, "abort_quiet", 32'(seen), 32'h0);
        end

        // Halfword store wrapping past the top of the address space.
        begin
`ifdef MEMCTRL_PERF_CNT_EN
            logic [31:0] p0;
            p0 = perf_mem_cyc;
`endif
            do_mem(1'b1, 32'hFFFFFFFF, 2'b01, 1'b0, 32'h0000A55A, 32'h0, 3);
`ifdef MEMCTRL_PERF_CNT_EN
            chk(perf_mem_cyc - p0 == 32'd2, "perf_mem_sh", perf_mem_cyc - p0, 32'd2);
`endif
        end
        do_mem(1'b0, 32'hFFFFFFFF, 2'b01, 1'b0, 32'h0, 32'hFFFFA55A, 4);

        repeat (3) @(posedge clk);
        chk(done_q.size() == 0, "done_queue_empty", 32'(done_q.size()), 32'h0);
        chk(wr_q.size() == 0, "write_queue_empty", 32'(wr_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
